// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for ahb_bram_ctrl.
//   master modport: drives select/address/control/write data, receives ready/resp/read data.
//   slave modport : the mirror image, used by the controller.
interface ahb_bram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_bram_ctrl.sv
// Zero-wait-state AHB-Lite slave in front of a 32-bit dual-port block RAM
// (port A: byte-enabled write, port B: registered read).
//   HCLK, HRESET : clock and asynchronous active-high reset
//   ahb          : AHB-Lite slave bus (ahb_bram_ctrl_if.slave)
//   bram_addra/bram_dina/bram_wea : RAM write port, driven during write data phases
//   bram_addrb/bram_doutb         : RAM read port, address taken straight from HADDR
// A read whose address phase lands on the data phase of a write to the same
// word would see stale RAM data, so the write data is captured and muxed in
// per byte lane on the following cycle.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_bram_ctrl_if.slave        ahb,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [31:0]           bram_dina,
    output logic [3:0]            bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);

    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            be;
    logic [31:0]           rdata;

    logic                  wr_pend_q,  wr_pend_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
    logic [3:0]            wr_be_q,    wr_be_d;
    logic [3:0]            fwd_be_q,   fwd_be_d;
    logic [31:0]           fwd_data_q, fwd_data_d;

    // High address bits alias and HTRANS[0] (NONSEQ vs SEQ) is irrelevant here.
    logic unused_bits;
    assign unused_bits = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

    always_comb begin
        accept   = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
        word_idx = ahb.HADDR[ADDR_WIDTH+1:2];

        case (ahb.HSIZE)
            3'd0:    be = 4'b0001 << ahb.HADDR[1:0];
            3'd1:    be = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase

        wr_pend_d = accept & ahb.HWRITE;
        wr_addr_d = wr_addr_q;
        wr_be_d   = wr_be_q;
        if (wr_pend_d) begin
            wr_addr_d = word_idx;
            wr_be_d   = be;
        end

        // HWDATA here belongs to the write in its data phase, which the RAM
        // only commits at this same edge, so the read port would miss it.
        fwd_be_d   = 4'b0000;
        fwd_data_d = fwd_data_q;
        if (accept && !ahb.HWRITE && wr_pend_q && (word_idx == wr_addr_q)) begin
            fwd_be_d   = wr_be_q;
            fwd_data_d = ahb.HWDATA;
        end

        for (int n = 0; n < 4; n++) begin
            rdata[8*n +: 8] = fwd_be_q[n] ? fwd_data_q[8*n +: 8] : bram_doutb[8*n +: 8];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_be_q    <= 4'b0000;
            fwd_be_q   <= 4'b0000;
            fwd_data_q <= 32'h0;
        end else begin
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_be_q    <= wr_be_d;
            fwd_be_q   <= fwd_be_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign bram_addra    = wr_addr_q;
    assign bram_dina     = ahb.HWDATA;
    assign bram_wea      = wr_pend_q ? wr_be_q : 4'b0000;
    assign bram_addrb    = word_idx;
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;
    assign ahb.HRDATA    = rdata;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
module tb_ahb_bram_ctrl;
    localparam int AW = 13;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        ready;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } xfer_t;

    logic          HCLK;
    logic          HRESET;
    logic [AW-1:0] bram_addra;
    logic [31:0]   bram_dina;
    logic [3:0]    bram_wea;
    logic [AW-1:0] bram_addrb;
    logic [31:0]   bram_doutb;

    ahb_bram_ctrl_if bus ();

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .ahb        (bus),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_wea   (bram_wea),
        .bram_addrb (bram_addrb),
        .bram_doutb (bram_doutb)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Environment: the block RAM itself (read-before-write on a collision).
    logic [31:0] ram [0:(1<<AW)-1];
    always @(posedge HCLK) begin
        for (int n = 0; n < 4; n++)
            if (bram_wea[n]) ram[bram_addra][8*n +: 8] <= bram_dina[8*n +: 8];
        bram_doutb <= ram[bram_addrb];
    end

    // Reference model: the memory as the bus master sees it, one transfer at a time.
    logic [31:0] model_mem [0:(1<<AW)-1];
    logic          ap_valid, ap_write, dp_valid, dp_write;
    logic [AW-1:0] ap_word, dp_word, exp_addrb;
    logic [3:0]    ap_be, dp_be, exp_wea;
    logic [31:0]   ap_data, dp_data, exp_rdata;
    logic          exp_rd, chk_en;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] a);
        if (size == 3'd0) return 4'(1 << a);
        if (size == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic xfer_t wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        return '{sel: 1'b1, trans: 2'b10, ready: 1'b1, write: 1'b1, addr: a, size: s, data: d};
    endfunction

    function automatic xfer_t rd(input logic [31:0] a);
        return '{sel: 1'b1, trans: 2'b10, ready: 1'b1, write: 1'b0, addr: a, size: 3'd2, data: 32'h0};
    endfunction

    function automatic xfer_t idle();
        return '{sel: 1'b0, trans: 2'b00, ready: 1'b1, write: 1'b0, addr: 32'h0, size: 3'd0, data: 32'h0};
    endfunction

    // One bus cycle: retire the write whose data phase just ended, move the
    // previous address phase into its data phase, drive a new address phase.
    task automatic bus_cycle(input xfer_t t);
        @(posedge HCLK);
        #1;
        if (dp_valid && dp_write)
            for (int n = 0; n < 4; n++)
                if (dp_be[n]) model_mem[dp_word][8*n +: 8] = dp_data[8*n +: 8];
        dp_valid = ap_valid;
        dp_write = ap_write;
        dp_word  = ap_word;
        dp_be    = ap_be;
        dp_data  = ap_data;
        if (dp_valid) t.ready = 1'b1;
        ap_valid = t.sel && t.ready && t.trans[1];
        ap_write = t.write;
        ap_word  = t.addr[AW+1:2];
        ap_be    = lanes(t.size, t.addr[1:0]);
        ap_data  = t.data;
        bus.HSEL   = t.sel;
        bus.HTRANS = t.trans;
        bus.HREADY = t.ready;
        bus.HWRITE = t.write;
        bus.HADDR  = t.addr;
        bus.HSIZE  = t.size;
        bus.HWDATA = (dp_valid && dp_write) ? dp_data : $urandom;
        exp_wea    = (dp_valid && dp_write) ? dp_be : 4'b0000;
        exp_rd     = dp_valid && !dp_write;
        exp_rdata  = model_mem[dp_word];
        exp_addrb  = t.addr[AW+1:2];
    endtask

    task automatic expect_rdata(input string name, input logic [31:0] v);
        @(negedge HCLK);
        #1;
        chk(name, bus.HRDATA, v);
    endtask

    always @(negedge HCLK) begin
        if (chk_en) begin
            chk("hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
            chk("hresp", {31'b0, bus.HRESP}, 32'd0);
            chk("wea", {28'b0, bram_wea}, {28'b0, exp_wea});
            chk("dina", bram_dina, bus.HWDATA);
            chk("addrb", {19'b0, bram_addrb}, {19'b0, exp_addrb});
            if (exp_wea != 4'b0000) chk("addra", {19'b0, bram_addra}, {19'b0, dp_word});
            if (exp_rd) chk("hrdata", bus.HRDATA, exp_rdata);
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]       = 32'h0;
            model_mem[i] = 32'h0;
        end
        bram_doutb = 32'h0;
        chk_en   = 1'b0;
        ap_valid = 1'b0; ap_write = 1'b0; ap_word = '0; ap_be = 4'b0; ap_data = 32'h0;
        dp_valid = 1'b0; dp_write = 1'b0; dp_word = '0; dp_be = 4'b0; dp_data = 32'h0;
        exp_wea  = 4'b0; exp_rd = 1'b0; exp_rdata = 32'h0; exp_addrb = '0;
        HRESET     = 1'b1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HREADY = 1'b1;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'h0;
        bus.HSIZE  = 3'd0;
        bus.HWDATA = 32'h5A5A_1234;

        #12;
        chk("rst_wea", {28'b0, bram_wea}, 32'h0);
        chk("rst_dina", bram_dina, 32'h5A5A_1234);
        chk("rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
        chk("rst_hresp", {31'b0, bus.HRESP}, 32'd0);
        HRESET = 1'b0;
        chk_en = 1'b1;

        // Word write, idle, word read.
        bus_cycle(wr(32'h10, 3'd2, 32'hDEAD_BEEF));
        bus_cycle(idle());
        @(negedge HCLK); #1;
        chk("t1_wea", {28'b0, bram_wea}, 32'hF);
        chk("t1_addra", {19'b0, bram_addra}, 32'd4);
        bus_cycle(rd(32'h10));
        bus_cycle(idle());
        expect_rdata("t1_rdata", 32'hDEAD_BEEF);

        // Byte writes into one word.
        bus_cycle(wr(32'h20, 3'd0, {4{8'h11}}));
        bus_cycle(wr(32'h21, 3'd0, {4{8'h22}}));
        bus_cycle(wr(32'h22, 3'd0, {4{8'h33}}));
        bus_cycle(wr(32'h23, 3'd0, {4{8'h44}}));
        @(negedge HCLK); #1;
        chk("t2_wea_b2", {28'b0, bram_wea}, 32'h4);
        bus_cycle(rd(32'h20));
        bus_cycle(idle());
        expect_rdata("t2_rdata", 32'h4433_2211);

        // Halfword write then immediate read: forwarded, then non-matching read.
        bus_cycle(wr(32'h40, 3'd2, 32'hAAAA_AAAA));
        bus_cycle(idle());
        bus_cycle(wr(32'h42, 3'd1, {2{16'h5555}}));
        bus_cycle(rd(32'h40));
        bus_cycle(idle());
        expect_rdata("t3_fwd", 32'h5555_AAAA);
        bus_cycle(wr(32'h42, 3'd1, {2{16'h5555}}));
        bus_cycle(rd(32'h44));
        bus_cycle(idle());
        expect_rdata("t3_nofwd", 32'h0);

        // Back-to-back writes then back-to-back reads.
        bus_cycle(wr(32'h0, 3'd2, 32'h0102_0304));
        bus_cycle(wr(32'h4, 3'd2, 32'h0A0B_0C0D));
        bus_cycle(rd(32'h4));
        bus_cycle(rd(32'h0));
        expect_rdata("t4_rd4", 32'h0A0B_0C0D);
        bus_cycle(idle());
        expect_rdata("t4_rd0", 32'h0102_0304);

        // Reset during a write data phase loses the write.
        bus_cycle(wr(32'h8, 3'd2, 32'h1234_5678));
        bus_cycle(idle());
        #2;
        HRESET   = 1'b1;
        dp_valid = 1'b0;
        exp_wea  = 4'b0000;
        #1;
        chk("t5_rst_wea", {28'b0, bram_wea}, 32'h0);
        @(negedge HCLK);
        #2;
        HRESET = 1'b0;
        bus_cycle(idle());
        bus_cycle(rd(32'h8));
        bus_cycle(idle());
        expect_rdata("t5_lost", 32'h0);

        // Aliasing, then non-transfers must not write.
        bus_cycle(wr(32'h0000_8000, 3'd2, 32'hCAFE_F00D));
        bus_cycle(idle());
        bus_cycle(rd(32'h0));
        bus_cycle('{sel: 1'b1, trans: 2'b01, ready: 1'b1, write: 1'b1, addr: 32'h0, size: 3'd2, data: 32'h1111_1111});
        expect_rdata("t6_alias", 32'hCAFE_F00D);
        bus_cycle('{sel: 1'b1, trans: 2'b00, ready: 1'b1, write: 1'b1, addr: 32'h0, size: 3'd2, data: 32'h2222_2222});
        bus_cycle('{sel: 1'b0, trans: 2'b10, ready: 1'b1, write: 1'b1, addr: 32'h0, size: 3'd2, data: 32'h3333_3333});
        bus_cycle(idle());
        @(negedge HCLK); #1;
        chk("t6_nowrite_wea", {28'b0, bram_wea}, 32'h0);
        bus_cycle(rd(32'h0));
        bus_cycle(idle());
        expect_rdata("t6_unchanged", 32'hCAFE_F00D);

        // Random traffic on a small window of words, with aliasing high bits.
        for (int i = 0; i < 400; i++) begin
            xfer_t t;
            t.sel   = ($urandom_range(0, 7) != 0);
            t.trans = 2'($urandom_range(0, 3));
            t.ready = ($urandom_range(0, 7) != 0);
            t.write = 1'($urandom_range(0, 1));
            t.addr  = (32'($urandom_range(0, 3)) << (AW + 2)) |
                      (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            t.size  = 3'($urandom_range(0, 7));
            t.data  = $urandom;
            bus_cycle(t);
        end
        bus_cycle(idle());
        bus_cycle(idle());
        @(negedge HCLK);
        #1;
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ahb_bram_ctrl.md
# ahb_bram_ctrl

AHB-Lite slave that sits directly upstream of the SoC's 32-bit dual-port block RAM, which has byte write enables and a registered read port. It turns Cortex-M0 bus transfers into RAM write-port and read-port controls and returns read data with zero wait states. It also forwards write data for a read that immediately follows a write to the same word.

## Interface

Parameters:
- ADDR_WIDTH, 13, RAM word-address width; the RAM holds 2^ADDR_WIDTH 32-bit words.

Ports:
- HCLK  in  1  single clock; also drives the RAM clock.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; only NONSEQ and SEQ (HTRANS[1]=1) are valid.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready from the interconnect.
- HREADYOUT  out  1  always 1.
- HRESP  out  1  always 0 (OKAY).
- HRDATA  out  32  read data, valid in the read data phase.
- bram_addra  out  ADDR_WIDTH  RAM write word address.
- bram_dina  out  32  RAM write data.
- bram_wea  out  4  RAM byte write enables; bit n covers byte lane n.
- bram_addrb  out  ADDR_WIDTH  RAM read word address.
- bram_doutb  in  32  registered RAM read data, valid one cycle after bram_addrb is sampled.

## Operation

- Transfer accepted when HSEL & HREADY & HTRANS[1]. IDLE, BUSY, unselected cycles, and cycles with HREADY=0 have no effect.
- Word index is HADDR[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses alias.
- Byte enables (be) are decoded in the address phase:
  - HSIZE=0: one-hot on HADDR[1:0].
  - HSIZE=1: HADDR[1] ? 4'b1100 : 4'b0011.
  - HSIZE=2 or larger: 4'b1111.
  - Unused low address bits are ignored.
- Write:
  - The address phase registers wr_pend=1, wr_addr and wr_be.
  - In the following data phase, the block drives bram_addra=wr_addr, bram_dina=HWDATA and bram_wea=wr_be, so the RAM is written at the end of the data phase.
  - bram_wea=0 whenever wr_pend=0. bram_addra and bram_dina always show wr_addr and HWDATA.
- Read:
  - bram_addrb is driven combinationally from the HADDR word index every cycle.
  - The RAM samples it at the end of the address phase, so bram_doutb is valid in the data phase.
- Forwarding: if a read is accepted while wr_pend=1 and the read word index equals wr_addr, the block registers fwd_be=wr_be and fwd_data=HWDATA. Otherwise fwd_be=0.
- HRDATA is assembled per byte lane n: fwd_be[n] ? fwd_data lane n : bram_doutb lane n.
- Back-to-back transfers of any mix are accepted every cycle; no stalls.

## Timing

- Reset values: wr_pend=0, wr_addr=0, wr_be=0, fwd_be=0, fwd_data=0. HREADYOUT=1 and HRESP=0 at all times.
- After reset, bram_wea=0 and bram_dina=HWDATA.
- Write latency: the RAM word is updated at the HCLK edge ending the data phase, one cycle after the address-phase edge.
- Read latency: HRDATA is valid in the cycle after the address phase (zero wait states).
- Write followed immediately by a read of the same word: the read returns the newly written bytes on the enabled lanes and the old RAM bytes on the other lanes.
- A read one or more cycles after the write needs no forwarding; the data is already in the RAM.
- A write whose address phase coincides with a previous write's data phase: the previous write commits this cycle and the new one commits in the next cycle. No conflict.
- HRESET asserted during a write data phase: wr_pend clears asynchronously, bram_wea drops to 0 immediately, and the write is lost. HRDATA forwarding is cleared.
- HRDATA outside a read data phase is don't-care. It still follows the lane mux.

## Test plan

- Word write 0xDEADBEEF to 0x0000_0010, IDLE, then word read of 0x10 -> HRDATA=0xDEADBEEF; bram_wea=4'b1111 for exactly one cycle with bram_addra=4.
- Starting from 0x00000000, byte writes 0x11 to 0x20, 0x22 to 0x21, 0x33 to 0x22, 0x44 to 0x23, then word read of 0x20 -> 0x44332211; the writes produce bram_wea 0001, 0010, 0100, 1000 respectively.
- Word 0x40 holds 0xAAAAAAAA; halfword write 0x5555 to 0x42 with the read of 0x40 in the very next address phase -> HRDATA=0x5555AAAA via forwarding. Same sequence reading 0x44 -> RAM data, no forwarding.
- Back-to-back writes to 0x0 and 0x4 followed by reads of 0x4 and 0x0 -> both values correct, with HREADYOUT=1 throughout.
- HRESET pulsed during the data phase of a word write of 0x12345678 to 0x8 (old value 0) -> bram_wea=0 from assertion onward, and a later read of 0x8 returns 0.
- Aliasing: a write of 0xCAFEF00D to 0x0000_8000 with ADDR_WIDTH=13 -> a read of 0x0 returns 0xCAFEF00D. IDLE and BUSY with HSEL=1, and HSEL=0 transfers -> no bram_wea activity.
